// File: rtl/switch_debounce.sv
// Per-bit two-flop synchronizer and hold-time debouncer for slide switches.
// Emits clean levels plus registered rise/fall/any_change strobes.
module switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] upd;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_comb begin
    differ = sync2 ^ stable;
    upd    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = differ[i] && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      stable     <= '0;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= switches_raw;
      sync2      <= sync1;
      stable     <= stable ^ upd;
      rise       <= upd & sync2;
      fall       <= upd & ~sync2;
      any_change <= |upd;
      // a return to the stable level restarts the hold window
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign switches = stable;

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized and directed bench for switch_debounce.
// A queue-based scoreboard checks every cycle against a history model.
module tb_switch_debounce;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw = '0;
  logic [W-1:0] switches;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any_change;

  int total = 0;
  int bad   = 0;

  switch_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switches_raw(raw),
    .switches(switches),
    .rise(rise),
    .fall(fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  // reference: two-stage delay, accept when last D samples all differ
  logic [W-1:0] p1, p2, mst, er, ef, updm;
  logic [W-1:0] hist[$];
  logic [3*W:0] expq[$];

  always @(posedge clk) begin
    if (rst) begin
      p1 = '0;
      p2 = '0;
      mst = '0;
      er = '0;
      ef = '0;
      hist = {};
      for (int j = 0; j < D; j++) hist.push_back('0);
    end else begin
      hist.push_back(p2);
      void'(hist.pop_front());
      updm = '0;
      for (int i = 0; i < W; i++) begin
        bit all;
        all = 1'b1;
        foreach (hist[j]) if (hist[j][i] == mst[i]) all = 1'b0;
        updm[i] = all;
      end
      er  = updm & ~mst;
      ef  = updm & mst;
      mst = mst ^ updm;
      p2  = p1;
      p1  = raw;
    end
    expq.push_back({mst, er, ef, |(er | ef)});
  end

  always @(posedge clk) begin
    logic [3*W:0] e, a;
    #1;
    a = {switches, rise, fall, any_change};
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty t=%0t got=%h", $time, a);
    end else begin
      e = expq.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t got=%h want=%h", $time, a, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [3*W:0] a,
                     input logic [3*W:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  function automatic logic [3*W:0] outs();
    return {switches, rise, fall, any_change};
  endfunction

  initial begin
    int pulses;
    int at;
    // reset with all switches high
    rst = 1'b1;
    raw = 4'hF;
    cyc(3);
    chk("reset_outs", outs(), '0);
    rst = 1'b0;
    cyc(5);
    chk("reset_wait", outs(), '0);
    cyc(1);
    chk("reset_rise", outs(), {4'hF, 4'hF, 4'h0, 1'b1});
    cyc(1);
    chk("reset_after", outs(), {4'hF, 4'h0, 4'h0, 1'b0});
    // back to zero, then clean step on bit 2
    raw = 4'h0;
    cyc(12);
    raw = 4'b0100;
    cyc(5);
    chk("step_wait", outs(), '0);
    cyc(1);
    chk("step_rise", outs(), {4'b0100, 4'b0100, 4'h0, 1'b1});
    // glitch on bit 0 for 3 cycles
    raw = 4'b0101;
    cyc(3);
    raw = 4'b0100;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (any_change) pulses++;
    end
    chk("glitch", {switches, 4'h0, 4'h0, 1'b0} | (pulses != 0),
        {4'b0100, 4'h0, 4'h0, 1'b0});
    // bounce on bit 1
    raw = 4'b0110; cyc(1);
    raw = 4'b0100; cyc(1);
    raw = 4'b0110; cyc(1);
    raw = 4'b0100; cyc(1);
    raw = 4'b0110;
    pulses = 0;
    at = -1;
    for (int k = 1; k <= 14; k++) begin
      cyc(1);
      if (rise[1]) begin
        pulses++;
        at = k;
      end
    end
    chk("bounce_count", (3*W+1)'(pulses), (3*W+1)'(1));
    chk("bounce_when", (3*W+1)'(at), (3*W+1)'(6));
    // simultaneous update
    raw = 4'b0011;
    cyc(12);
    chk("simul_pre", outs(), {4'b0011, 4'h0, 4'h0, 1'b0});
    raw = 4'b1100;
    cyc(6);
    chk("simul", outs(), {4'b1100, 4'b1100, 4'b0011, 1'b1});
    cyc(1);
    chk("simul_after", outs(), {4'b1100, 4'h0, 4'h0, 1'b0});
    // reset mid-pending on bit 3
    raw = 4'h0;
    cyc(12);
    raw = 4'b1000;
    cyc(4);
    rst = 1'b1;
    cyc(2);
    chk("midrst_outs", outs(), '0);
    rst = 1'b0;
    cyc(5);
    chk("midrst_wait", outs(), '0);
    cyc(1);
    chk("midrst_rise", outs(), {4'b1000, 4'b1000, 4'h0, 1'b1});
    // random phase
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(199) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(2, 1));
        rst = 1'b0;
      end
      if ($urandom_range(5) == 0) raw[$urandom_range(W-1)] ^= 1'b1;
      cyc(1);
    end
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Per-bit synchronizer and debouncer for the board slide switches. It sits directly upstream of the switch-to-LED stage and feeds it clean, glitch-free switch levels. It also provides single-cycle rise/fall strobes for downstream control logic. Each bit is filtered independently: a new level is accepted only after it has been held for a programmable number of consecutive clock cycles.

## Interface
Parameters:
- WIDTH, 4, number of switch bits.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized level must persist before acceptance (20 ms at 50 MHz). Legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width. Derived; never overridden.

Ports:
- clk, input, 1, system clock. All state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- switches_raw, input, WIDTH, asynchronous switch pins.
- switches, output, WIDTH, debounced switch levels. This port feeds the LED stage's switches input.
- rise, output, WIDTH, one-cycle pulse per bit when the debounced level goes 0→1.
- fall, output, WIDTH, one-cycle pulse per bit when the debounced level goes 1→0.
- any_change, output, 1, one-cycle pulse. Equals |(rise | fall).

## Operation
- Each bit uses a 2-flop synchronizer: sync1 <= switches_raw, then sync2 <= sync1. Nothing downstream of sync1 samples switches_raw directly.
- Each bit has a CNT_W-bit counter cnt[i] and a stable register stable[i]. switches = stable.
- Per-bit state, implicit in the counter:
  - IDLE: sync2 == stable.
  - PENDING: sync2 != stable.
- Each cycle, per bit:
  - If sync2 == stable: cnt <= 0. Any pending change is abandoned, so glitches are rejected.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0. Assert rise if sync2 = 1, fall if sync2 = 0, for exactly this update cycle.
  - Else: cnt <= cnt + 1.
- rise, fall and any_change are registered. They go high in the same cycle that switches changes, and are low in every other cycle.
- Bits are fully independent. Several bits may update in the same cycle, and any_change is then a single pulse.
- Counter arithmetic is unsigned. cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset clears sync1, sync2, stable, cnt, rise, fall and any_change to 0. Asserting rst mid-PENDING discards the pending change.
- After reset, if a switch is physically high, it is accepted as a normal 0→1 transition with a rise pulse, DEBOUNCE_CYCLES+2 cycles after rst deasserts.

## Timing
- Reset values: switches = 0, rise = 0, fall = 0, any_change = 0.
- Latency: if a raw level is settled before edge k and held, switches updates at edge k+DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges counting from edge k-1's successor, made up of 2 synchronizer edges plus DEBOUNCE_CYCLES counting edges.
- Rejection: a change visible on sync2 for fewer than DEBOUNCE_CYCLES consecutive cycles never reaches switches.
- Bounce: any return of sync2 to the stable value during PENDING restarts the count from 0.
- Pulses are exactly 1 cycle wide. Two pulses on the same bit are separated by at least DEBOUNCE_CYCLES cycles.
- No combinational path from switches_raw to any output.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES = 4, WIDTH = 4.
- Reset: hold rst for 3 cycles with switches_raw = 4'hF -> all outputs 0 during reset. After release, switches = 4'hF exactly 6 edges later, with rise = 4'hF and any_change = 1 for 1 cycle.
- Clean step: from switches = 0, set switches_raw[2] = 1 and hold -> switches = 4'b0100 after 6 edges, rise = 4'b0100 for 1 cycle, fall = 0.
- Glitch: pulse switches_raw[0] high for 3 cycles, then low -> switches, rise and fall stay 0 throughout.
- Bounce: on bit 1, toggle 1,0,1,0,1 at 1-cycle spacing, then hold 1 -> exactly one rise[1] pulse, occurring 6 edges after the final 0→1, with no intermediate pulses.
- Simultaneous: from switches = 4'b0011, drive switches_raw = 4'b1100 in one cycle -> after 6 edges switches = 4'b1100, rise = 4'b1100, fall = 4'b0011 and any_change = 1, all in the same cycle.
- Reset mid-operation: assert rst 3 cycles into a pending 0→1 on bit 3 -> no rise pulse and switches = 0. After release with raw still high, rise[3] occurs 6 edges later.
